// File: rtl/wb_arb_pkg.sv
// Shared types and widths for the two-master Wishbone round-robin arbiter.
package wb_arb_pkg;

  localparam int OUTSTANDING_W = 4;
  localparam int WDOG_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_t;

  function automatic arb_state_t grant_state(input logic master);
    return master ? ST_GRANT1 : ST_GRANT0;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// No-ack watchdog: counts busy cycles without progress and flags expiry.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic busy,
  output logic expire
);

  logic [WDOG_W-1:0] count;

  // An ack or a release in the expiry cycle suppresses the expiry.
  assign expire = busy && !clear && (count == WDOG_W'(TIMEOUT_CYCLES));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear || !busy || expire) begin
      count <= '0;
    end else begin
      count <= count + WDOG_W'(1);
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master pipelined Wishbone arbiter: per-tenure round-robin grant,
// outstanding-request tracking and a no-ack watchdog.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int MAX_OUTSTANDING = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_stall,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_stall,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ack,
  input  logic        s_stall,
  input  logic [31:0] s_rdata
);

  arb_state_t               state;
  logic                     last;
  logic [OUTSTANDING_W-1:0] outstanding;

  logic in_grant, sel1, grant_cyc, other_cyc, at_limit;
  logic ack_valid, accept, release_bus, wdog_busy, wdog_clear, wdog_expire;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    in_grant    = 1'b0;
    sel1        = 1'b0;
    grant_cyc   = 1'b0;
    other_cyc   = 1'b0;
    at_limit    = 1'b0;
    ack_valid   = 1'b0;
    release_bus = 1'b0;
    s_cyc       = 1'b0;
    s_stb       = 1'b0;
    m0_ack      = 1'b0;
    m1_ack      = 1'b0;

    in_grant  = (state == ST_GRANT0) || (state == ST_GRANT1);
    sel1      = (state == ST_GRANT1);
    grant_cyc = in_grant && (sel1 ? m1_cyc : m0_cyc);
    other_cyc = sel1 ? m0_cyc : m1_cyc;
    at_limit  = (outstanding == OUTSTANDING_W'(MAX_OUTSTANDING));
    // Acks with nothing outstanding are strays and never reach a master.
    ack_valid   = in_grant && s_ack && (outstanding != '0);
    release_bus = in_grant && !grant_cyc;

    s_cyc  = grant_cyc;
    s_stb  = grant_cyc && (sel1 ? m1_stb : m0_stb) && !at_limit;
    m0_ack = (state == ST_GRANT0) && ack_valid;
    m1_ack = (state == ST_GRANT1) && ack_valid;
  end

  assign s_we     = sel1 ? m1_we    : m0_we;
  assign s_addr   = sel1 ? m1_addr  : m0_addr;
  assign s_wdata  = sel1 ? m1_wdata : m0_wdata;
  assign m0_stall = (state != ST_GRANT0) || s_stall || at_limit;
  assign m1_stall = (state != ST_GRANT1) || s_stall || at_limit;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  assign accept     = s_stb && !s_stall;
  assign wdog_busy  = in_grant && (outstanding != '0);
  assign wdog_clear = ack_valid || release_bus;

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wdog_clear),
    .busy   (wdog_busy),
    .expire (wdog_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      last        <= 1'b1;
      outstanding <= '0;
      m0_err      <= 1'b0;
      m1_err      <= 1'b0;
    end else begin
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          outstanding <= '0;
          if (m0_cyc && m1_cyc) begin
            state <= grant_state(!last);
          end else if (m0_cyc) begin
            state <= ST_GRANT0;
          end else if (m1_cyc) begin
            state <= ST_GRANT1;
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          if (!grant_cyc) begin
            // Release beats a same-cycle expiry; a waiting master takes over with no idle gap.
            last        <= sel1;
            state       <= other_cyc ? grant_state(!sel1) : ST_IDLE;
            outstanding <= '0;
          end else if (wdog_expire) begin
            m0_err      <= !sel1;
            m1_err      <= sel1;
            last        <= sel1;
            state       <= ST_IDLE;
            outstanding <= '0;
          end else if (accept && !ack_valid) begin
            outstanding <= outstanding + OUTSTANDING_W'(1);
          end else if (ack_valid && !accept) begin
            outstanding <= outstanding - OUTSTANDING_W'(1);
          end
        end
        default: begin
          state       <= ST_IDLE;
          outstanding <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: one instance with an 8-cycle watchdog,
// one with the default watchdog for the deep-pipeline scenario.
module tb_wb_rr_arbiter;

  localparam logic [31:0] LED_ADDR = 32'h3000_0000;
  localparam logic [31:0] BTN_ADDR = 32'h3000_0004;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        s_ack, s_stall;
  logic [31:0] s_rdata;

  logic        m0_ack, m0_stall, m0_err, m1_ack, m1_stall, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_addr, s_wdata;

  logic        p_m0_ack, p_m0_stall, p_m0_err, p_m1_ack, p_m1_stall, p_m1_err;
  logic [31:0] p_m0_rdata, p_m1_rdata;
  logic        p_s_cyc, p_s_stb, p_s_we;
  logic [31:0] p_s_addr, p_s_wdata;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.TIMEOUT_CYCLES(8), .MAX_OUTSTANDING(15)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_stall(m0_stall), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_stall(m1_stall), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_stall(s_stall), .s_rdata(s_rdata)
  );

  wb_rr_arbiter #(.TIMEOUT_CYCLES(255), .MAX_OUTSTANDING(15)) dut_p (
    .clk(clk), .reset(reset),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(p_m0_ack), .m0_stall(p_m0_stall), .m0_err(p_m0_err), .m0_rdata(p_m0_rdata),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(p_m1_ack), .m1_stall(p_m1_stall), .m1_err(p_m1_err), .m1_rdata(p_m1_rdata),
    .s_cyc(p_s_cyc), .s_stb(p_s_stb), .s_we(p_s_we), .s_addr(p_s_addr), .s_wdata(p_s_wdata),
    .s_ack(s_ack), .s_stall(s_stall), .s_rdata(s_rdata)
  );

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
    m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
    s_ack = 1'b0; s_stall = 1'b0; s_rdata = '0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    check_bit("rst_s_cyc",    s_cyc,    1'b0);
    check_bit("rst_s_stb",    s_stb,    1'b0);
    check_bit("rst_m0_ack",   m0_ack,   1'b0);
    check_bit("rst_m1_ack",   m1_ack,   1'b0);
    check_bit("rst_m0_err",   m0_err,   1'b0);
    check_bit("rst_m1_err",   m1_err,   1'b0);
    check_bit("rst_m0_stall", m0_stall, 1'b1);
    check_bit("rst_m1_stall", m1_stall, 1'b1);

    // Single master write: request at t, on the bus at t+1, ack at t+2.
    next_cycle();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_addr = LED_ADDR; m0_wdata = 32'h0000_00A5;
    #1;
    check_bit("single_idle_stb", s_stb, 1'b0);
    next_cycle();
    check_bit("single_stb", s_stb, 1'b1);
    check_bit("single_we", s_we, 1'b1);
    check_word("single_addr", s_addr, LED_ADDR);
    check_word("single_wdata", s_wdata, 32'h0000_00A5);
    check_bit("single_m0_stall", m0_stall, 1'b0);
    check_bit("single_m1_stall_t1", m1_stall, 1'b1);
    next_cycle();
    m0_stb = 1'b0; m0_we = 1'b0; s_ack = 1'b1;
    #1;
    check_bit("single_m0_ack", m0_ack, 1'b1);
    check_bit("single_m1_ack", m1_ack, 1'b0);
    check_bit("single_m1_stall_t2", m1_stall, 1'b1);
    next_cycle();
    s_ack = 1'b0; m0_cyc = 1'b0;
    #1;
    check_bit("single_release_cyc", s_cyc, 1'b0);
    next_cycle();
    check_bit("single_idle_stall", m0_stall, 1'b1);

    // Tie after reset goes to m0, then direct handoff, then alternating ties.
    do_reset();
    m0_addr = LED_ADDR; m1_addr = BTN_ADDR; m0_cyc = 1'b1; m1_cyc = 1'b1;
    #1;
    check_bit("tie_idle_stall", m0_stall, 1'b1);
    next_cycle();
    check_word("tie1_addr", s_addr, LED_ADDR);
    check_bit("tie1_m0_stall", m0_stall, 1'b0);
    check_bit("tie1_m1_stall", m1_stall, 1'b1);
    next_cycle();
    m0_cyc = 1'b0;
    #1;
    check_bit("handoff_k_cyc", s_cyc, 1'b0);
    next_cycle();
    check_bit("handoff_k1_cyc", s_cyc, 1'b1);
    check_word("handoff_k1_addr", s_addr, BTN_ADDR);
    check_bit("handoff_m1_stall", m1_stall, 1'b0);
    check_bit("handoff_m0_stall", m0_stall, 1'b1);
    next_cycle();
    m1_cyc = 1'b0;
    next_cycle();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    next_cycle();
    check_word("tie3_addr", s_addr, LED_ADDR);
    check_bit("tie3_m0_stall", m0_stall, 1'b0);
    next_cycle();
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    next_cycle();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    next_cycle();
    check_word("tie4_addr", s_addr, BTN_ADDR);
    check_bit("tie4_m1_stall", m1_stall, 1'b0);
    next_cycle();
    m0_cyc = 1'b0; m1_cyc = 1'b0;

    // 15 accepted reads fill the window; the 16th waits for the first ack.
    do_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_addr = BTN_ADDR;
    for (int i = 1; i <= 15; i++) begin
      next_cycle();
      check_bit($sformatf("pipe_stb_%0d", i), p_s_stb, 1'b1);
    end
    next_cycle();
    check_bit("pipe_full_stall", p_m1_stall, 1'b1);
    check_bit("pipe_full_stb", p_s_stb, 1'b0);
    next_cycle();
    check_bit("pipe_hold_stall", p_m1_stall, 1'b1);
    next_cycle();
    s_ack = 1'b1; s_rdata = 32'h5A5A_0001;
    #1;
    check_bit("pipe_ack", p_m1_ack, 1'b1);
    check_word("pipe_rdata", p_m1_rdata, 32'h5A5A_0001);
    check_bit("pipe_ack_stall", p_m1_stall, 1'b1);
    next_cycle();
    s_ack = 1'b0;
    #1;
    check_bit("pipe_16th_stall", p_m1_stall, 1'b0);
    check_bit("pipe_16th_stb", p_s_stb, 1'b1);
    next_cycle();
    m1_cyc = 1'b0; m1_stb = 1'b0;

    // Timeout: accepted at a1, counter holds 8 during a10, err during a11.
    do_reset();
    s_rdata = '0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_addr = BTN_ADDR;
    next_cycle();
    check_bit("to_stb", s_stb, 1'b1);
    next_cycle();
    m0_stb = 1'b0; m1_cyc = 1'b1; m1_addr = LED_ADDR;
    #1;
    check_bit("to_no_err_2", m0_err, 1'b0);
    for (int i = 3; i <= 10; i++) begin
      next_cycle();
      check_bit($sformatf("to_no_err_%0d", i), m0_err, 1'b0);
    end
    check_bit("to_a10_cyc", s_cyc, 1'b1);
    next_cycle();
    check_bit("to_err", m0_err, 1'b1);
    check_bit("to_m1_err", m1_err, 1'b0);
    check_bit("to_idle_cyc", s_cyc, 1'b0);
    check_bit("to_idle_stall", m0_stall, 1'b1);
    next_cycle();
    m0_cyc = 1'b0;
    #1;
    check_bit("to_err_pulse", m0_err, 1'b0);
    check_bit("to_m1_cyc", s_cyc, 1'b1);
    check_word("to_m1_addr", s_addr, LED_ADDR);
    check_bit("to_m1_stall", m1_stall, 1'b0);
    next_cycle();
    m1_cyc = 1'b0;

    // Ack in the expiry cycle wins; a later stray ack at count 0 is dropped.
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = BTN_ADDR;
    next_cycle();
    next_cycle();
    m0_stb = 1'b0;
    for (int i = 3; i <= 9; i++) next_cycle();
    next_cycle();
    s_ack = 1'b1; s_rdata = 32'hC0DE_0008;
    #1;
    check_bit("ackexp_ack", m0_ack, 1'b1);
    check_word("ackexp_rdata", m0_rdata, 32'hC0DE_0008);
    next_cycle();
    s_ack = 1'b0;
    #1;
    check_bit("ackexp_no_err", m0_err, 1'b0);
    check_bit("ackexp_still_grant", s_cyc, 1'b1);
    next_cycle();
    s_ack = 1'b1;
    #1;
    check_bit("stray_grant_ack", m0_ack, 1'b0);
    next_cycle();
    s_ack = 1'b0; m0_cyc = 1'b0;

    // Release in the expiry cycle wins; a stray ack in IDLE reaches nobody.
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    next_cycle();
    next_cycle();
    m0_stb = 1'b0;
    for (int i = 3; i <= 9; i++) next_cycle();
    next_cycle();
    m0_cyc = 1'b0;
    next_cycle();
    check_bit("relexp_no_err", m0_err, 1'b0);
    check_bit("relexp_idle_cyc", s_cyc, 1'b0);
    s_ack = 1'b1;
    #1;
    check_bit("stray_idle_m0_ack", m0_ack, 1'b0);
    check_bit("stray_idle_m1_ack", m1_ack, 1'b0);
    next_cycle();
    s_ack = 1'b0;

    // Reset with 3 outstanding drops the tenure and the in-flight ack.
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = LED_ADDR; m1_addr = BTN_ADDR;
    next_cycle();
    next_cycle();
    next_cycle();
    next_cycle();
    m0_stb = 1'b0; reset = 1'b1; s_ack = 1'b1;
    #1;
    check_bit("mid_pre_ack", m0_ack, 1'b1);
    next_cycle();
    reset = 1'b0; m1_cyc = 1'b1;
    #1;
    check_bit("mid_s_cyc", s_cyc, 1'b0);
    check_bit("mid_m0_ack", m0_ack, 1'b0);
    check_bit("mid_m1_ack", m1_ack, 1'b0);
    check_bit("mid_m0_err", m0_err, 1'b0);
    check_bit("mid_m1_err", m1_err, 1'b0);
    check_bit("mid_m0_stall", m0_stall, 1'b1);
    check_bit("mid_m1_stall", m1_stall, 1'b1);
    next_cycle();
    s_ack = 1'b0;
    #1;
    check_bit("mid_tie_m0_stall", m0_stall, 1'b0);
    check_bit("mid_tie_m1_stall", m1_stall, 1'b1);
    check_word("mid_tie_addr", s_addr, LED_ADDR);
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Two-master, one-slave Wishbone (pipelined, stall-capable) arbiter that shares the user-area peripheral bus between the management-core Wishbone port (master 0) and a logic-analyzer-driven test master (master 1). It grants the bus per `cyc` tenure with round-robin fairness and tracks outstanding requests. A watchdog terminates tenures whose slave stops acknowledging. It sits between the masters and the peripheral address decoder (LED/button block at 0x3000_0000/0x3000_0004).

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: consecutive no-ack cycles with outstanding requests before the watchdog fires. Range 2..65535.
- `MAX_OUTSTANDING`, 15: limit on accepted-but-unacked requests per tenure. Range 1..15.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `m0_cyc`, `m0_stb`, `m0_we`  in  1 each  master 0 request
- `m0_addr`, `m0_wdata`  in  32 each  master 0 address/write data
- `m0_ack`, `m0_stall`, `m0_err`  out  1 each  master 0 response
- `m0_rdata`  out  32  master 0 read data
- `m1_*`  same set as `m0_*`  master 1
- `s_cyc`, `s_stb`, `s_we`  out  1 each  to slave
- `s_addr`, `s_wdata`  out  32 each  to slave
- `s_ack`, `s_stall`  in  1 each  from slave
- `s_rdata`  in  32  from slave

## Operation
- FSM states: IDLE, GRANT0, GRANT1. State register `last` (1 bit) holds the most recently granted master.
- IDLE:
  - `s_cyc` = `s_stb` = 0.
  - Both `mN_stall` = 1.
  - If exactly one `mN_cyc` is high, go to GRANTN.
  - If both are high, grant master `!last`.
- GRANTN:
  - `s_cyc`/`s_stb`/`s_we`/`s_addr`/`s_wdata` are driven from master N.
  - `mN_stall = s_stall | (outstanding == MAX_OUTSTANDING)`. `s_stb` is masked to 0 when the outstanding count is at the limit.
  - `mN_ack = s_ack`. The other master sees `stall` = 1 and `ack` = 0.
  - `m0_rdata` = `m1_rdata` = `s_rdata` (broadcast). Masters qualify read data with `ack`.
- Release: on the cycle `mN_cyc` = 0 in GRANTN, `last` <= N.
  - If the other master's `cyc` = 1, go directly to GRANT(other).
  - Otherwise go to IDLE.
- Outstanding counter (4 bit):
  - +1 on `s_stb & !s_stall`, -1 on `s_ack`. Simultaneous increment and decrement leave it unchanged.
  - Cleared on every state change.
  - An `s_ack` arriving when the count is 0 is dropped and not routed to any master.
- Watchdog:
  - 16-bit counter. Cleared when the count is 0, on `s_ack`, or on a state change.
  - Otherwise increments.
  - When it reaches `TIMEOUT_CYCLES`:
    - `mN_err` is registered high for exactly 1 cycle.
    - FSM goes to IDLE, outstanding is cleared, `last` <= N.
  - The master must drop `cyc` after `err`. IDLE holds `s_cyc` low for at least 1 cycle, which aborts the slave.
- Simultaneous events:
  - Watchdog expiry and `s_ack` in the same cycle: the ack wins, the counter clears, no err.
  - Master drop and expiry in the same cycle: release wins, no err.

## Timing
- Reset values:
  - State IDLE, `last` = 1 (master 0 wins the first tie), counters 0.
  - `s_cyc` = `s_stb` = 0, `mN_ack` = `mN_err` = 0, `mN_stall` = 1.
  - `s_addr`/`s_wdata`/`mN_rdata` follow the combinational muxes.
- Reset mid-tenure: `s_cyc` is low from the cycle after `reset` is sampled. In-flight acks are dropped.
- Arbitration latency: `mN_cyc` rising at cycle t in IDLE -> GRANTN from t+1; the first `s_stb` is visible at t+1.
- Handoff: master 0 drops `cyc` at cycle k with master 1 waiting -> `s_cyc` low at k (master 0's value), master 1 on the bus at k+1. There is no idle gap.
- Zero added latency on `ack`/`rdata`/`stall` inside a grant (combinational from registered state).
- `err` is registered: asserted on the cycle after the counter reaches `TIMEOUT_CYCLES`, aligned with the state change to IDLE.

## Structure
- Package `wb_arb_pkg`: state encoding (IDLE/GRANT0/GRANT1), `OUTSTANDING_W` = 4, `WDOG_W` = 16.
- Sub-module `wb_arb_watchdog`: counter plus expiry compare, with inputs `clear`, `busy` and output `expire`.
- Top: FSM, round-robin pointer, outstanding counter, muxes.

## Test plan
- **Single master:** m0 writes 0x0000_00A5 to 0x3000_0000, slave acks next cycle -> `s_stb` at t+1, `m0_ack` 1 cycle later, `m1_stall` = 1 throughout.
- **Tie after reset:** both `cyc` rise in the same cycle -> GRANT0. After m0 releases, direct handoff to m1 at k+1. A subsequent tie -> GRANT1 only if m0 was last, otherwise GRANT0 (verify alternation over 4 tenures).
- **Pipelining:** m1 issues 15 back-to-back reads of 0x3000_0004 with the slave stalling acks -> `m1_stall` = 1 at count 15, the 16th request is held, and it is accepted the cycle after the first `ack`.
- **Timeout:** `TIMEOUT_CYCLES` = 8, m0 issues 1 read and the slave never acks -> `m0_err` pulses exactly 1 cycle at 8 cycles after the last progress cycle, `s_cyc` = 0 for at least 1 cycle, then m1 (pending) is granted.
- **Boundary collisions:** ack on the exact expiry cycle -> no err. Stray `s_ack` in IDLE -> no master ack.
- **Reset mid-tenure:** assert `reset` with 3 outstanding -> next cycle `s_cyc` = 0, all acks/err = 0, stalls = 1, and the next tie grants m0.
